led_pwm_ctrl: RTL and testbench
===============================

Name: led_pwm_ctrl

Overview:
Parametrised multi-channel LED indicator driver that replaces the fixed free-running blink counter on the board status LEDs.
- Each channel is independently configured to OFF, ON (PWM brightness), BLINK or BREATHE through a single-cycle write strobe.
- Configuration changes are applied only at PWM frame boundaries, so outputs never glitch.
- Sits in the top level, driving led_r/g/b pads from osc25.

Parameters:
NUM_CH, 3, number of LED channels
PWM_BITS, 8, PWM counter/brightness width (frame = 2^PWM_BITS ticks)
PRESCALE, 98, clocks per PWM tick (25 MHz / 98 / 256 ≈ 1 kHz frame); minimum 1
PERIOD_BITS, 12, width of per-channel blink/breathe period (in frames)

Ports:
clk  in  1  system clock (osc25 domain)
reset  in  1  synchronous, active-high reset
cfg_wr  in  1  config write strobe, one cycle
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=BREATHE
cfg_level  in  PWM_BITS  brightness / breathe peak
cfg_period  in  PERIOD_BITS  frames per blink half-period / per breathe step
led_out  out  NUM_CH  LED drive, active-high, registered
frame_tick  out  1  one-cycle pulse on the last clock of each PWM frame

Behaviour:
- Reset: led_out=0, frame_tick=0, all counters 0, every channel's shadow and active config = OFF/level 0/period 0, breathe dir=UP, blink phase=0.
- Prescaler counts 0..PRESCALE-1. tick=1 when prescaler==PRESCALE-1, then wraps to 0.
- pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0.
- frame_tick = tick && pwm_cnt==all-ones.
- cfg_wr with cfg_ch<NUM_CH writes the shadow config for that channel. cfg_ch>=NUM_CH is ignored.
- Multiple writes within one frame: the last one wins.
- On frame_tick, active<=shadow for every channel whose shadow changed since the last apply. An applied channel clears its period counter, brightness b=0, dir=UP, phase=0.
- A write in the same cycle as frame_tick lands in the shadow and is applied at the following boundary.
- Per-channel duty d:
  - OFF: d=0.
  - ON: d=level.
  - BLINK: d = phase ? 0 : level.
  - BREATHE: d=b.
- Output: led_out[i] <= (d == all-ones) ? 1 : (pwm_cnt < d). Registered, 1 clock latency from pwm_cnt. d=0 gives constant 0; all-ones gives constant 1 (no 1/2^N dip).
- Period counter: advances on frame_tick. Effective period P = max(cfg_period,1). When the counter reaches P-1 it clears and raises a step event.
- BLINK step: toggle phase.
- BREATHE state machine (UP/DOWN), on each step event:
  - UP: if b<level then b++; else dir<=DOWN and b--, except when level==0, where b stays 0 and dir stays UP.
  - DOWN: if b>0 then b--; else dir<=UP and b++ (if level>0).
  - Triangle period = 2·level·P frames.
- Level lowered mid-breathe is not applicable: config only changes at apply, and apply resets b.
- Reset asserted mid-frame takes effect on the next clock edge: all state returns to reset values, no partial frame completes.

Optional Feature:
LED_PWM_GAMMA_EN
- Defined: duty passes through a registered square-law map, d' = (d·d) >> PWM_BITS, with all-ones mapping to all-ones. Adds 1 clock of output latency. Gives perceptually linear breathing.
- Undefined: linear duty, latency 1.

Decomposition:
- Package led_pwm_pkg: mode enum (LED_OFF, LED_ON, LED_BLINK, LED_BREATHE), breathe dir enum, channel-config struct {mode, level, period}.
- Sub-module led_pwm_chan: one channel's shadow/active config, period counter, blink/breathe state and output compare. Instantiated NUM_CH times.
- The top of the block owns the prescaler, pwm_cnt and frame_tick.

Test Plan:
- PRESCALE=1, PWM_BITS=4. After reset: led_out=0 and frame_tick pulses every 16 clocks.
- ch0 ON level 4, written mid-frame: output unchanged until the next frame_tick, then exactly 4 high clocks per 16. Level 15 gives constant high; level 0 gives constant low.
- ch1 BLINK level 15, period 2: 32 clocks high, 32 low, repeating. Period 0 behaves as period 1.
- ch2 BREATHE level 3, period 1: per-frame duty sequence 0,1,2,3,2,1,0,1…. Level 0 holds duty 0.
- Write cfg_ch=3 with NUM_CH=3: no channel changes. Two writes to ch0 within one frame (ON 2, then ON 8): duty 8 is applied. Write coincident with frame_tick: applied one frame later.
- Assert reset mid-breathe: the next cycle shows led_out=0 and all channels OFF. With LED_PWM_GAMMA_EN defined, ON level 8 (PWM_BITS=4) gives duty 4 and one extra clock of latency.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared types for the multi-channel LED PWM driver.
// Consumers: led_pwm_chan, led_pwm_ctrl (optional gamma map under LED_PWM_GAMMA_EN).
package led_pwm_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: shadow/active config, period counter, blink/breathe state, PWM compare.
// Define LED_PWM_GAMMA_EN to insert a registered square-law duty map (+1 clock latency).
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [PWM_BITS-1:0]    pwm_cnt,
  input  logic                   cfg_we,
  input  led_mode_e              cfg_mode,
  input  logic [PWM_BITS-1:0]    cfg_level,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  output logic                   led
);

  typedef struct packed {
    led_mode_e               mode;
    logic [PWM_BITS-1:0]     level;
    logic [PERIOD_BITS-1:0]  period;
  } chan_cfg_t;

  localparam logic [PWM_BITS-1:0] FULL = '1;

  chan_cfg_t              shadow, active;
  logic                   dirty;
  logic [PERIOD_BITS-1:0] per_cnt, per_last;
  logic [PWM_BITS-1:0]    bright, bright_nxt, duty;
  breathe_dir_e           dir, dir_nxt;
  logic                   phase, step;

  // A period of 0 behaves as 1 frame.
  assign per_last = (active.period == '0) ? '0 : active.period - 1'b1;
  assign step     = frame_tick && !dirty && (per_cnt == per_last);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dir_nxt    = dir;
    bright_nxt = bright;
    if (step && active.mode == LED_BREATHE) begin
      unique case (dir)
        DIR_UP: begin
          if (bright < active.level) begin
            bright_nxt = bright + 1'b1;
          end else if (active.level != '0) begin
            dir_nxt    = DIR_DOWN;
            bright_nxt = bright - 1'b1;
          end
        end
        DIR_DOWN: begin
          if (bright != '0) begin
            bright_nxt = bright - 1'b1;
          end else if (active.level != '0) begin
            dir_nxt    = DIR_UP;
            bright_nxt = bright + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '{mode: LED_OFF, level: '0, period: '0};
      active  <= '{mode: LED_OFF, level: '0, period: '0};
      dirty   <= 1'b0;
      per_cnt <= '0;
      bright  <= '0;
      dir     <= DIR_UP;
      phase   <= 1'b0;
    end else begin
      if (cfg_we) begin
        shadow <= '{mode: cfg_mode, level: cfg_level, period: cfg_period};
        dirty  <= 1'b1;
      end
      if (frame_tick) begin
        if (dirty) begin
          // A write coincident with the apply stays pending for the next boundary.
          active  <= shadow;
          dirty   <= cfg_we;
          per_cnt <= '0;
          bright  <= '0;
          dir     <= DIR_UP;
          phase   <= 1'b0;
        end else begin
          per_cnt <= step ? '0 : per_cnt + 1'b1;
          bright  <= bright_nxt;
          dir     <= dir_nxt;
          if (step && active.mode == LED_BLINK) phase <= ~phase;
        end
      end
    end
  end

  always_comb begin
    duty = '0;
    unique case (active.mode)
      LED_OFF:     duty = '0;
      LED_ON:      duty = active.level;
      LED_BLINK:   duty = phase ? '0 : active.level;
      LED_BREATHE: duty = bright;
      default:     duty = '0;
    endcase
  end

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  logic [PWM_BITS-1:0]   duty_g, duty_q, cnt_q;

  assign duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
  assign duty_g  = (duty == FULL) ? FULL : PWM_BITS'(duty_sq >> PWM_BITS);

  // pwm_cnt is delayed alongside the mapped duty so the compare stays frame-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q <= '0;
      cnt_q  <= '0;
      led    <= 1'b0;
    end else begin
      duty_q <= duty_g;
      cnt_q  <= pwm_cnt;
      led    <= (duty_q == FULL) || (cnt_q < duty_q);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) led <= 1'b0;
    else       led <= (duty == FULL) || (pwm_cnt < duty);
  end
`endif

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM driver top: prescaler, frame counter, frame_tick, channel array.
// Optional LED_PWM_GAMMA_EN adds a square-law duty map inside each channel.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int  NUM_CH      = 3,
  parameter int  PWM_BITS    = 8,
  parameter int  PRESCALE    = 98,
  parameter int  PERIOD_BITS = 12,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_wr,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [PWM_BITS-1:0]    cfg_level,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  output logic [NUM_CH-1:0]      led_out,
  output logic                   frame_tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick       = (presc == PS_W'(PRESCALE - 1));
  assign frame_tick = tick && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Out-of-range channel numbers match no decode and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_chan #(
      .PWM_BITS    (PWM_BITS),
      .PERIOD_BITS (PERIOD_BITS)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .pwm_cnt    (pwm_cnt),
      .cfg_we     (cfg_wr && (cfg_ch == CH_W'(i))),
      .cfg_mode   (led_mode_e'(cfg_mode)),
      .cfg_level  (cfg_level),
      .cfg_period (cfg_period),
      .led        (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl (PRESCALE=1, PWM_BITS=4): per-frame output patterns scored
// against a queue of expected waveforms. Honours LED_PWM_GAMMA_EN for latency and duty map.
module tb_led_pwm_ctrl;
  import led_pwm_pkg::*;

  localparam int NUM_CH      = 3;
  localparam int PWM_BITS    = 4;
  localparam int PRESCALE    = 1;
  localparam int PERIOD_BITS = 12;
  localparam int FRAME       = 16;
`ifdef LED_PWM_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cfg_wr = 1'b0;
  logic [1:0]             cfg_ch = '0;
  logic [1:0]             cfg_mode = '0;
  logic [PWM_BITS-1:0]    cfg_level = '0;
  logic [PERIOD_BITS-1:0] cfg_period = '0;
  logic [NUM_CH-1:0]      led_out;
  logic                   frame_tick;

  always #5 clk = ~clk;

  led_pwm_ctrl #(
    .NUM_CH      (NUM_CH),
    .PWM_BITS    (PWM_BITS),
    .PRESCALE    (PRESCALE),
    .PERIOD_BITS (PERIOD_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_level  (cfg_level),
    .cfg_period (cfg_period),
    .led_out    (led_out),
    .frame_tick (frame_tick)
  );

  typedef struct {
    string       tag;
    int          ch;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected per-frame waveform (bit k = output while pwm_cnt == k) for a given duty.
  function automatic logic [15:0] exp_vec(input int d);
    logic [15:0] v;
    int e;
    e = d;
`ifdef LED_PWM_GAMMA_EN
    if (d != 15) e = (d * d) / 16;
`endif
    for (int k = 0; k < FRAME; k++) v[k] = (e == 15) || (k < e);
    return v;
  endfunction

  task automatic push_frame(input string tag, input int d0, input int d1, input int d2);
    sb.push_back('{tag: $sformatf("%s_ch0", tag), ch: 0, vec: exp_vec(d0)});
    sb.push_back('{tag: $sformatf("%s_ch1", tag), ch: 1, vec: exp_vec(d1)});
    sb.push_back('{tag: $sformatf("%s_ch2", tag), ch: 2, vec: exp_vec(d2)});
  endtask

  task automatic wait_ft();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 64);
    check("ft_seen", 32'(frame_tick), 32'd1);
  endtask

  task automatic drive_cfg(input int ch, input logic [1:0] mode, input int level, input int period);
    cfg_ch     = 2'(ch);
    cfg_mode   = mode;
    cfg_level  = PWM_BITS'(level);
    cfg_period = PERIOD_BITS'(period);
    cfg_wr     = 1'b1;
  endtask

  task automatic write_cfg(input int ch, input logic [1:0] mode, input int level, input int period);
    drive_cfg(ch, mode, level, period);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Leaves the bench a few clocks into a frame so writes are clearly mid-frame.
  task automatic align_mid();
    wait_ft();
    repeat (3) @(negedge clk);
  endtask

  // Captures n consecutive frames starting after the next (or current) frame_tick and
  // scores each one against the queued expectations.
  task automatic sample_frames(input int n, input bit do_wait);
    logic [15:0] obs [NUM_CH];
    exp_t e;
    if (do_wait) wait_ft();
    repeat (LAT) begin
      @(negedge clk);
      cfg_wr = 1'b0;
    end
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < FRAME; k++) begin
        @(negedge clk);
        cfg_wr = 1'b0;
        for (int c = 0; c < NUM_CH; c++) obs[c][k] = led_out[c];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check(e.tag, 32'(obs[e.ch]), 32'(e.vec));
        end else begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end
      end
    end
  endtask

  task automatic check_period();
    int n;
    wait_ft();
    @(negedge clk);
    check("ft_width", 32'(frame_tick), 32'd0);
    n = 1;
    while (!frame_tick && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ft_period", 32'(n), 32'd16);
  endtask

  initial begin
    logic [15:0] pre_vec;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led_out), 32'd0);
    check("reset_ft", 32'(frame_tick), 32'd0);
    reset = 1'b0;
    check_period();
    push_frame("idle", 0, 0, 0);
    sample_frames(1, 1'b1);

    // ON level 4 written mid-frame: held off until the boundary
    align_mid();
    write_cfg(0, LED_ON, 4, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("pre_apply", 32'(led_out[0]), 32'd0);
    end
    push_frame("on4", 4, 0, 0);
    push_frame("on4b", 4, 0, 0);
    sample_frames(2, 1'b1);

    align_mid();
    write_cfg(0, LED_ON, 15, 0);
    push_frame("on15", 15, 0, 0);
    sample_frames(1, 1'b1);

    align_mid();
    write_cfg(0, LED_ON, 0, 0);
    push_frame("on0", 0, 0, 0);
    sample_frames(1, 1'b1);

    // BLINK level 15, period 2: two frames high, two low
    align_mid();
    write_cfg(0, LED_OFF, 0, 0);
    write_cfg(1, LED_BLINK, 15, 2);
    push_frame("blink2_f0", 0, 15, 0);
    push_frame("blink2_f1", 0, 15, 0);
    push_frame("blink2_f2", 0, 0, 0);
    push_frame("blink2_f3", 0, 0, 0);
    push_frame("blink2_f4", 0, 15, 0);
    push_frame("blink2_f5", 0, 15, 0);
    sample_frames(6, 1'b1);

    // Period 0 behaves as period 1
    align_mid();
    write_cfg(1, LED_BLINK, 15, 0);
    push_frame("blink0_f0", 0, 15, 0);
    push_frame("blink0_f1", 0, 0, 0);
    push_frame("blink0_f2", 0, 15, 0);
    push_frame("blink0_f3", 0, 0, 0);
    sample_frames(4, 1'b1);

    // BREATHE level 3, period 1: triangle 0,1,2,3,2,1,0,1
    align_mid();
    write_cfg(1, LED_OFF, 0, 0);
    write_cfg(2, LED_BREATHE, 3, 1);
    push_frame("br3_f0", 0, 0, 0);
    push_frame("br3_f1", 0, 0, 1);
    push_frame("br3_f2", 0, 0, 2);
    push_frame("br3_f3", 0, 0, 3);
    push_frame("br3_f4", 0, 0, 2);
    push_frame("br3_f5", 0, 0, 1);
    push_frame("br3_f6", 0, 0, 0);
    push_frame("br3_f7", 0, 0, 1);
    sample_frames(8, 1'b1);

    // BREATHE level 0 holds duty 0
    align_mid();
    write_cfg(2, LED_BREATHE, 0, 1);
    push_frame("br0_f0", 0, 0, 0);
    push_frame("br0_f1", 0, 0, 0);
    push_frame("br0_f2", 0, 0, 0);
    sample_frames(3, 1'b1);

    // Out-of-range channel is ignored
    align_mid();
    write_cfg(3, LED_ON, 15, 0);
    push_frame("bad_ch", 0, 0, 0);
    push_frame("bad_ch2", 0, 0, 0);
    sample_frames(2, 1'b1);

    // Last write within a frame wins
    align_mid();
    write_cfg(0, LED_ON, 2, 0);
    write_cfg(0, LED_ON, 8, 0);
    push_frame("last_wins", 8, 0, 0);
    sample_frames(1, 1'b1);

    // Write coincident with frame_tick is applied one boundary later
    wait_ft();
    drive_cfg(0, LED_ON, 15, 0);
    push_frame("coinc_old", 8, 0, 0);
    push_frame("coinc_new", 15, 0, 0);
    sample_frames(2, 1'b0);

    // Reset asserted mid-breathe
    align_mid();
    write_cfg(0, LED_OFF, 0, 0);
    write_cfg(2, LED_BREATHE, 3, 1);
    push_frame("rbr_f0", 0, 0, 0);
    push_frame("rbr_f1", 0, 0, 1);
    sample_frames(2, 1'b1);
    @(negedge clk);
    pre_vec = exp_vec(2);
    check("pre_reset", 32'(led_out[2]), 32'(pre_vec[0]));
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_led", 32'(led_out), 32'd0);
    check("mid_reset_ft", 32'(frame_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_frame("post_reset_f0", 0, 0, 0);
    push_frame("post_reset_f1", 0, 0, 0);
    sample_frames(2, 1'b1);
    check_period();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
